// File: rtl/nxm_mul_pkg.sv
// Shared constants for the N x M multiplier-adder: default operand widths
// and the result-width rule used by the interface and the top level.
package nxm_mul_pkg;

    localparam int WIDTH1_DEF = 4;
    localparam int WIDTH2_DEF = 3;

    // x*y + u + v never exceeds 2^(N+M)-1, so N+M bits hold every result.
    function automatic int res_width(input int w1, input int w2);
        return w1 + w2;
    endfunction

endpackage

// File: rtl/nxm_mul_if.sv
// Operand/result bundle for nxm_mul. The master drives the four operands,
// and the slave (the multiplier) returns the registered result.
interface nxm_mul_if
    import nxm_mul_pkg::*;
#(
    parameter int WIDTH1 = WIDTH1_DEF,
    parameter int WIDTH2 = WIDTH2_DEF
);
    logic [WIDTH1-1:0]                    x;
    logic [WIDTH1-1:0]                    u;
    logic [WIDTH2-1:0]                    y;
    logic [WIDTH2-1:0]                    v;
    logic [res_width(WIDTH1, WIDTH2)-1:0] s;

    modport master (output x, u, y, v, input s);
    modport slave  (input x, u, y, v, output s);
endinterface

// File: rtl/nxm_mul_cell.sv
// Array cell: partial-product AND gate feeding a full adder.
module mul_cell (
    input  logic a,
    input  logic b,
    input  logic sin,
    input  logic cin,
    output logic sout,
    output logic cout
);
    logic w_pp;

    assign w_pp = a & b;
    assign sout = w_pp ^ sin ^ cin;
    assign cout = (w_pp & sin) | (w_pp & cin) | (sin & cin);
endmodule

// File: rtl/nxm_mul.sv
// Unsigned N x M array multiplier-adder: s = x*y + u + v, registered.
// Row j adds x & y[j] to the previous row's shifted partial sum, with v[j]
// entering as the carry-in at the LSB cell and the carry rippling left.
// Row 0 takes u as its sum inputs. Each row retires one low result bit;
// the last row supplies the upper bits plus its final carry.
module nxm_mul
    import nxm_mul_pkg::*;
#(
    parameter int WIDTH1 = WIDTH1_DEF,
    parameter int WIDTH2 = WIDTH2_DEF
)(
    nxm_mul_if.slave io,
    input  logic     clk,
    input  logic     reset
);
    localparam int RES_W = res_width(WIDTH1, WIDTH2);

    logic [RES_W-1:0] w_result;
    logic [RES_W-1:0] r_s;

    for (genvar j = 0; j < WIDTH2; j++) begin : row
        for (genvar i = 0; i < WIDTH1; i++) begin : col
            logic w_si;
            logic w_ci;
            logic w_so;
            logic w_co;

            // Sum input: u on the first row, otherwise the previous row
            // shifted down one position, with its final carry on top.
            if (j == 0) begin : g_sin_top
                assign w_si = io.u[i];
            end else if (i == WIDTH1 - 1) begin : g_sin_msb
                assign w_si = row[j-1].col[WIDTH1-1].w_co;
            end else begin : g_sin_mid
                assign w_si = row[j-1].col[i+1].w_so;
            end

            // Carry input: v[j] at the LSB edge, ripple from the right otherwise.
            if (i == 0) begin : g_cin_lsb
                assign w_ci = io.v[j];
            end else begin : g_cin_mid
                assign w_ci = row[j].col[i-1].w_co;
            end

            mul_cell u_cell (
                .a    (io.x[i]),
                .b    (io.y[j]),
                .sin  (w_si),
                .cin  (w_ci),
                .sout (w_so),
                .cout (w_co)
            );
        end

        assign w_result[j] = row[j].col[0].w_so;
    end

    for (genvar i = 1; i < WIDTH1; i++) begin : g_upper
        assign w_result[WIDTH2-1+i] = row[WIDTH2-1].col[i].w_so;
    end

    assign w_result[RES_W-1] = row[WIDTH2-1].col[WIDTH1-1].w_co;

    // Output register: reset clears the result, otherwise capture the array sum.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s <= '0;
        end else begin
            r_s <= w_result;
        end
    end

    assign io.s = r_s;
endmodule

// File: tb/tb_nxm_mul.sv
// Self-checking bench for nxm_mul (default 4x3) against an arithmetic model.
module tb_nxm_mul;
    localparam int N = 4;
    localparam int M = 3;
    localparam int W = N + M;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    nxm_mul_if #(.WIDTH1(N), .WIDTH2(M)) bus ();

    nxm_mul #(.WIDTH1(N), .WIDTH2(M)) dut (
        .io    (bus.slave),
        .clk   (clk),
        .reset (reset)
    );

    function automatic logic [W-1:0] model(input int xv, input int uv, input int yv, input int vv);
        int r;
        r = xv * yv + uv + vv;
        return W'(r);
    endfunction

    task automatic drive(input int xv, input int uv, input int yv, input int vv);
        bus.x = N'(xv);
        bus.u = N'(uv);
        bus.y = M'(yv);
        bus.v = M'(vv);
    endtask

    // Wait for the next rising edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            drive($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7));
            tick();
            total++;
            if (bus.s !== '0) begin
                bad++;
                $display("FAIL reset_edge%0d: got %0d want 0", k, bus.s);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_directed();
        int tv [4][4] = '{'{14, 5, 2, 6}, '{10, 5, 4, 6}, '{12, 5, 7, 6}, '{11, 5, 5, 6}};
        int want [4]  = '{39, 51, 95, 66};
        for (int k = 0; k < 4; k++) begin
            drive(tv[k][0], tv[k][1], tv[k][2], tv[k][3]);
            tick();
            total++;
            if (bus.s !== W'(want[k])) begin
                bad++;
                $display("FAIL directed%0d: got %0d want %0d", k, bus.s, want[k]);
            end
        end
    endtask

    task automatic test_hold();
        logic [W-1:0] held;
        drive(9, 3, 6, 2);
        tick();
        held = model(9, 3, 6, 2);
        total++;
        if (bus.s !== held) begin
            bad++;
            $display("FAIL hold_load: got %0d want %0d", bus.s, held);
        end
        for (int k = 0; k < 3; k++) begin
            drive($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7));
            #1;
            total++;
            if (bus.s !== held) begin
                bad++;
                $display("FAIL hold_between_edges%0d: got %0d want %0d", k, bus.s, held);
            end
        end
        drive(1, 0, 1, 0);
        tick();
        total++;
        if (bus.s !== W'(1)) begin
            bad++;
            $display("FAIL hold_next_edge: got %0d want 1", bus.s);
        end
    endtask

    task automatic test_bounds();
        drive(15, 15, 7, 7);
        tick();
        total++;
        if (bus.s !== W'(127)) begin
            bad++;
            $display("FAIL bound_max: got %0d want 127", bus.s);
        end
        drive(0, 0, 0, 0);
        tick();
        total++;
        if (bus.s !== W'(0)) begin
            bad++;
            $display("FAIL bound_zero: got %0d want 0", bus.s);
        end
    endtask

    task automatic test_reset_midstream();
        drive(13, 2, 3, 1);
        tick();
        drive(15, 0, 7, 0);
        reset = 1'b1;
        tick();
        total++;
        if (bus.s !== W'(0)) begin
            bad++;
            $display("FAIL midreset_clear: got %0d want 0", bus.s);
        end
        reset = 1'b0;
        tick();
        total++;
        if (bus.s !== W'(105)) begin
            bad++;
            $display("FAIL midreset_resume: got %0d want 105", bus.s);
        end
    endtask

    // Every one of the 2^14 operand sets, visited in a random order given
    // by an odd-multiplier/offset permutation of the index space.
    task automatic test_sweep();
        int mulk;
        int offs;
        int idx;
        int xv, uv, yv, vv;
        logic [W-1:0] want;
        mulk = int'($urandom_range(0, 8191)) * 2 + 1;
        offs = int'($urandom_range(0, 16383));
        for (int k = 0; k < 16384; k++) begin
            idx = (k * mulk + offs) & 16383;
            xv = idx & 15;
            uv = (idx >> 4) & 15;
            yv = (idx >> 8) & 7;
            vv = (idx >> 11) & 7;
            drive(xv, uv, yv, vv);
            want = model(xv, uv, yv, vv);
            tick();
            total++;
            if (bus.s !== want) begin
                bad++;
                if (bad < 20)
                    $display("FAIL sweep x=%0d u=%0d y=%0d v=%0d: got %0d want %0d", xv, uv, yv, vv, bus.s, want);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0);
        test_reset();
        test_directed();
        test_hold();
        test_bounds();
        test_reset_midstream();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
